// File: rtl/fighter_player_core.sv
`default_nettype none
// ============================================================================
// Module   : fighter_player_core
// Brief    : Per-player fighter state: position, health, regen, invulnerability.
// Revision : 1.0
// ============================================================================
module fighter_player_core #(
  parameter int NUM_POS      = 3,
  parameter int START_POS    = 2,
  parameter int HEALTH_W     = 2,
  parameter int MAX_HEALTH   = 3,
  parameter int REGEN_WAITS  = 2,
  parameter int KICK_RANGE   = 2,
  parameter int PUNCH_RANGE  = 1,
  parameter int INVULN_STEPS = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                isGameOver,
  input  logic                actionEnable,
  input  logic [2:0]          own_action,
  input  logic [2:0]          opp_action,
  input  logic [NUM_POS-1:0]  opp_pos,
  output logic [NUM_POS-1:0]  pos,
  output logic [HEALTH_W-1:0] health,
  output logic                ko,
  output logic                hit_taken,
  output logic                invuln
);

  localparam int IW = $clog2(NUM_POS) + 1;
  localparam int WW = $clog2(REGEN_WAITS + 1);
  localparam int VW = (INVULN_STEPS < 1) ? 1 : $clog2(INVULN_STEPS + 1);
  localparam int HW = HEALTH_W + 1;

  localparam logic [2:0]          C_KICK  = 3'b000;
  localparam logic [2:0]          C_PUNCH = 3'b001;
  localparam logic [2:0]          C_AWAIT = 3'b010;
  localparam logic [2:0]          C_JUMP  = 3'b011;
  localparam logic [IW-1:0]       C_LAST  = IW'(NUM_POS - 1);
  localparam logic [HEALTH_W-1:0] C_MAX_H = HEALTH_W'(MAX_HEALTH);

  logic [IW-1:0]       idx_q, idx_d;
  logic [HEALTH_W-1:0] health_q, health_d;
  logic [WW-1:0]       regen_q, regen_d;
  logic [VW-1:0]       inv_q, inv_d;
  logic                hit_q, hit_d;

  logic [IW-1:0] opp_idx, new_idx, lim, move_amt, d_pre, d_post;
  logic [HW-1:0] dmg;
  logic          opp_valid, opp_left, step_en, clash_k, clash_p, apply;

  always_comb begin
    opp_idx = '0;
    for (int i = 0; i < NUM_POS; i++) begin
      if (opp_pos[i]) opp_idx = IW'(i);
    end
  end

  assign opp_valid = (opp_pos != '0) && ((opp_pos & (opp_pos - NUM_POS'(1))) == '0)
                     && (opp_pos != pos);
  assign step_en   = actionEnable && !isGameOver && opp_valid;
  assign opp_left  = opp_idx < idx_q;
  assign d_pre     = opp_left ? (idx_q - opp_idx) : (opp_idx - idx_q);
  assign clash_k   = (own_action == C_KICK) && (opp_action == C_KICK)
                     && (int'(d_pre) <= KICK_RANGE);
  assign clash_p   = (own_action == C_PUNCH) && (opp_action == C_PUNCH)
                     && (int'(d_pre) <= PUNCH_RANGE);
  assign move_amt  = own_action[0] ? IW'(2) : IW'(1);

  // Moves clamp at the wall and at the cell next to the opponent.
  always_comb begin
    new_idx = idx_q;
    lim     = '0;
    if (clash_k) begin
      if (opp_left) new_idx = (idx_q == C_LAST) ? idx_q : idx_q + IW'(1);
      else          new_idx = (idx_q == '0)     ? idx_q : idx_q - IW'(1);
    end else if (own_action[2]) begin
      if (!own_action[1]) begin
        lim     = opp_left ? opp_idx + IW'(1) : '0;
        new_idx = (idx_q < lim + move_amt) ? lim : idx_q - move_amt;
      end else begin
        lim     = opp_left ? C_LAST : opp_idx - IW'(1);
        new_idx = (idx_q + move_amt > lim) ? lim : idx_q + move_amt;
      end
    end
  end

  assign d_post = (new_idx > opp_idx) ? (new_idx - opp_idx) : (opp_idx - new_idx);

  always_comb begin
    dmg = '0;
    if (!clash_k && !clash_p) begin
      if ((opp_action == C_KICK) && (int'(d_post) <= KICK_RANGE) && (own_action != C_JUMP))
        dmg = HW'(1);
      else if ((opp_action == C_PUNCH) && (int'(d_post) <= PUNCH_RANGE))
        dmg = HW'(2);
    end
  end

  assign apply = (dmg != '0) && (inv_q == '0);

  always_comb begin
    idx_d    = idx_q;
    health_d = health_q;
    regen_d  = regen_q;
    inv_d    = inv_q;
    hit_d    = 1'b0;
    if (step_en) begin
      idx_d = new_idx;
      if (apply) begin
        health_d = ({1'b0, health_q} <= dmg) ? '0 : health_q - dmg[HEALTH_W-1:0];
        hit_d    = 1'b1;
        inv_d    = VW'(INVULN_STEPS);
        regen_d  = '0;
      end else begin
        if (inv_q != '0) inv_d = inv_q - VW'(1);
        if (own_action == C_AWAIT) begin
          if (regen_q == WW'(REGEN_WAITS - 1)) begin
            regen_d = '0;
            if (health_q != C_MAX_H) health_d = health_q + HEALTH_W'(1);
          end else begin
            regen_d = regen_q + WW'(1);
          end
        end else begin
          regen_d = '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      idx_q    <= IW'(START_POS);
      health_q <= C_MAX_H;
      regen_q  <= '0;
      inv_q    <= '0;
      hit_q    <= 1'b0;
    end else begin
      idx_q    <= idx_d;
      health_q <= health_d;
      regen_q  <= regen_d;
      inv_q    <= inv_d;
      hit_q    <= hit_d;
    end
  end

  always_comb begin
    pos = '0;
    for (int i = 0; i < NUM_POS; i++) pos[i] = (idx_q == IW'(i));
  end

  assign health    = health_q;
  assign ko        = (health_q == '0);
  assign hit_taken = hit_q;
  assign invuln    = (inv_q != '0);

endmodule
`default_nettype wire
